// File: rtl/xbar_bridge_pkg.sv
// Shared helpers for the XBAR bridge response tracker.
// Provides one-hot decode (head mux select) and one-hot validity check.
// Helpers take a fixed 64-bit vector; callers zero-extend N_SLAVE-wide values.
package xbar_bridge_pkg;

  // Widest slave vector the helpers accept, and the index width that covers it.
  localparam int MAX_SLAVE_W = 64;
  localparam int IDX_W       = 6;

  // OR of the set-bit indices; exact for a one-hot input.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_SLAVE_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_SLAVE_W; i++) begin
      if (v[i]) idx = idx | i[IDX_W-1:0];
    end
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [MAX_SLAVE_W-1:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

endpackage

// File: rtl/xbar_bridge_resp_tracker_if.sv
// Bundle of request-side and response-side signals of one bridge master.
// Names keep the tracker's view: *_i are driven into the tracker, *_o out of it.
// Modports: slave = tracker side, master = environment side.
interface xbar_bridge_resp_tracker_if #(
  parameter int N_SLAVE         = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                          req_i;
  logic                          gnt_i;
  logic [N_SLAVE-1:0]            destination_i;
  logic                          req_stall_o;
  logic [N_SLAVE-1:0]            data_r_valid_i;
  logic [N_SLAVE*DATA_WIDTH-1:0] data_r_rdata_i;
  logic [N_SLAVE-1:0]            data_r_opc_i;
  logic                          data_r_valid_o;
  logic [DATA_WIDTH-1:0]         data_r_rdata_o;
  logic                          data_r_opc_o;
  logic [CNT_W-1:0]              outstanding_o;
  logic                          error_o;

  modport slave (
    input  req_i, gnt_i, destination_i,
    input  data_r_valid_i, data_r_rdata_i, data_r_opc_i,
    output req_stall_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o,
    output outstanding_o, error_o
  );

  modport master (
    output req_i, gnt_i, destination_i,
    output data_r_valid_i, data_r_rdata_i, data_r_opc_i,
    input  req_stall_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o,
    input  outstanding_o, error_o
  );

endinterface

// File: rtl/bridge_dest_fifo.sv
// In-order FIFO of one-hot destinations, depth a power of two.
// Ports: push/wdata write at tail, pop advances head, rdata = head entry,
//        count/full/empty from a registered occupancy counter. Contents not reset.
module bridge_dest_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap by natural overflow; occupancy alone decides full/empty.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/xbar_bridge_resp_tracker.sv
// Tracks granted destinations in order and returns the head slave's response, registered.
// Ports: clk/rst plus the slave modport of the bridge bus interface.
// Latency: slave response cycle N -> data_r_valid_o cycle N+1; req_stall_o when tracker full.
module xbar_bridge_resp_tracker
  import xbar_bridge_pkg::*;
#(
  parameter int N_SLAVE         = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input logic clk,
  input logic rst,
  xbar_bridge_resp_tracker_if.slave bus
);

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  stray;
  logic                  bad_dest;
  logic [N_SLAVE-1:0]    head;
  logic [CNT_W-1:0]      count;
  logic [MAX_SLAVE_W-1:0] head_ext;
  logic [MAX_SLAVE_W-1:0] dest_ext;
  logic [IDX_W-1:0]      head_idx;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic                  opc_sel;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  opc_q,   opc_d;
  logic                  error_q, error_d;

  bridge_dest_fifo #(
    .WIDTH (N_SLAVE),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.destination_i),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Head response mux, selected by the decoded head index.
  always_comb begin
    head_ext              = '0;
    head_ext[N_SLAVE-1:0] = head;
    head_idx              = onehot_to_idx(head_ext);
    rdata_sel             = '0;
    opc_sel               = 1'b0;
    for (int k = 0; k < N_SLAVE; k++) begin
      if (head_idx == k[IDX_W-1:0]) begin
        rdata_sel = bus.data_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        opc_sel   = bus.data_r_opc_i[k];
      end
    end
  end

  always_comb begin
    dest_ext              = '0;
    dest_ext[N_SLAVE-1:0] = bus.destination_i;
    accept   = bus.req_i & bus.gnt_i;
    pop      = ~empty & (|(bus.data_r_valid_i & head));
    // A pop frees a slot on the same edge, so a push at full is fine alongside it.
    push     = accept & (~full | pop);
    // Any valid bit not belonging to the head (or any bit at all when empty).
    stray    = empty ? (|bus.data_r_valid_i) : (|(bus.data_r_valid_i & ~head));
    bad_dest = accept & ~is_onehot(dest_ext);
    error_d  = error_q | stray | (accept & ~push) | bad_dest;
    valid_d  = pop;
    rdata_d  = pop ? rdata_sel : rdata_q;
    opc_d    = pop ? opc_sel   : opc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      opc_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      opc_q   <= opc_d;
      error_q <= error_d;
    end
  end

  assign bus.data_r_valid_o = valid_q;
  assign bus.data_r_rdata_o = rdata_q;
  assign bus.data_r_opc_o   = opc_q;
  assign bus.error_o        = error_q;
  assign bus.outstanding_o  = count;
  assign bus.req_stall_o    = full;

endmodule

// File: tb/tb_xbar_bridge_resp_tracker.sv
// Bench for xbar_bridge_resp_tracker: directed vector table, a reset-mid-flight
// sequence, then random in-order traffic against a queue-based reference model.
// Slave k always returns data rbase + k so the delivered slave is identifiable.
module tb_xbar_bridge_resp_tracker;

  localparam int NS  = 16;
  localparam int DW  = 32;
  localparam int MO  = 4;
  localparam int CW  = $clog2(MO + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xbar_bridge_resp_tracker_if #(.N_SLAVE(NS), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) bus ();

  xbar_bridge_resp_tracker #(.N_SLAVE(NS), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          rst, req, gnt;
    logic [NS-1:0] dest, vld;
    logic [DW-1:0] rbase;
    logic [NS-1:0] opc;
    logic          e_vld;
    logic [DW-1:0] e_rdata;
    logic          e_opc;
    logic [CW-1:0] e_out;
    logic          e_stall, e_err;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  task automatic add(input logic r, input logic q, input logic g, input logic [NS-1:0] d,
                     input logic [NS-1:0] v, input logic [DW-1:0] rb, input logic [NS-1:0] o,
                     input logic ev, input logic [DW-1:0] er, input logic eo,
                     input logic [CW-1:0] en, input logic es, input logic ee);
    vec_t t;
    t.rst = r; t.req = q; t.gnt = g; t.dest = d; t.vld = v; t.rbase = rb; t.opc = o;
    t.e_vld = ev; t.e_rdata = er; t.e_opc = eo; t.e_out = en; t.e_stall = es; t.e_err = ee;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input logic r, input logic q, input logic g, input logic [NS-1:0] d,
                      input logic [NS-1:0] v, input logic [DW-1:0] rb, input logic [NS-1:0] o);
    rst                = r;
    bus.req_i          = q;
    bus.gnt_i          = g;
    bus.destination_i  = d;
    bus.data_r_valid_i = v;
    bus.data_r_opc_i   = o;
    for (int k = 0; k < NS; k++) bus.data_r_rdata_i[k*DW +: DW] = rb + DW'(k);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [DW-1:0] er,
                         input logic eo, input logic [CW-1:0] en, input logic es, input logic ee);
    chk({tag, "_vld"},   64'(bus.data_r_valid_o), 64'(ev));
    chk({tag, "_rdata"}, 64'(bus.data_r_rdata_o), 64'(er));
    chk({tag, "_opc"},   64'(bus.data_r_opc_o),   64'(eo));
    chk({tag, "_out"},   64'(bus.outstanding_o),  64'(en));
    chk({tag, "_stall"}, 64'(bus.req_stall_o),    64'(es));
    chk({tag, "_err"},   64'(bus.error_o),        64'(ee));
  endtask

  // Reference model state for the random phase.
  int            mq[$];
  logic          m_vld, m_opc, m_err;
  logic [DW-1:0] m_rdata;

  initial begin
    bus.req_i = 0; bus.gnt_i = 0; bus.destination_i = '0;
    bus.data_r_valid_i = '0; bus.data_r_rdata_i = '0; bus.data_r_opc_i = '0;

    //   rst req gnt dest     vld      rbase         opc      ev er            eo out st er
    add(1, 0, 0, 16'h0000, 16'h0000, 32'h0,        16'h0,    0, 32'h0,        0, 0, 0, 0);
    // single read to slave 2, response three cycles after grant
    add(0, 1, 1, 16'h0004, 16'h0000, 32'h0,        16'h0,    0, 32'h0,        0, 1, 0, 0);
    add(0, 0, 0, 16'h0000, 16'h0000, 32'h0,        16'h0,    0, 32'h0,        0, 1, 0, 0);
    add(0, 0, 0, 16'h0000, 16'h0000, 32'h0,        16'h0,    0, 32'h0,        0, 1, 0, 0);
    add(0, 0, 0, 16'h0000, 16'h0004, 32'hDEADBEED, 16'h0,    1, 32'hDEADBEEF, 0, 0, 0, 0);
    add(0, 0, 0, 16'h0000, 16'h0000, 32'h0,        16'h0,    0, 32'hDEADBEEF, 0, 0, 0, 0);
    // fill to four, then push/pop at full, then drain in order
    add(0, 1, 1, 16'h0001, 16'h0000, 32'h0,        16'h0,    0, 32'hDEADBEEF, 0, 1, 0, 0);
    add(0, 1, 1, 16'h0002, 16'h0000, 32'h0,        16'h0,    0, 32'hDEADBEEF, 0, 2, 0, 0);
    add(0, 1, 1, 16'h0004, 16'h0000, 32'h0,        16'h0,    0, 32'hDEADBEEF, 0, 3, 0, 0);
    add(0, 1, 1, 16'h0008, 16'h0000, 32'h0,        16'h0,    0, 32'hDEADBEEF, 0, 4, 1, 0);
    add(0, 1, 1, 16'h0020, 16'h0001, 32'h100,      16'h0,    1, 32'h100,      0, 4, 1, 0);
    add(0, 0, 0, 16'h0000, 16'h0002, 32'h200,      16'h0002, 1, 32'h201,      1, 3, 0, 0);
    add(0, 0, 0, 16'h0000, 16'h0004, 32'h300,      16'h0,    1, 32'h302,      0, 2, 0, 0);
    add(0, 0, 0, 16'h0000, 16'h0008, 32'h400,      16'h0008, 1, 32'h403,      1, 1, 0, 0);
    add(0, 0, 0, 16'h0000, 16'h0020, 32'h500,      16'h0,    1, 32'h505,      0, 0, 0, 0);
    // fill again, fifth accept with no pop is a violation
    add(0, 1, 1, 16'h0001, 16'h0000, 32'h0,        16'h0,    0, 32'h505,      0, 1, 0, 0);
    add(0, 1, 1, 16'h0002, 16'h0000, 32'h0,        16'h0,    0, 32'h505,      0, 2, 0, 0);
    add(0, 1, 1, 16'h0004, 16'h0000, 32'h0,        16'h0,    0, 32'h505,      0, 3, 0, 0);
    add(0, 1, 1, 16'h0008, 16'h0000, 32'h0,        16'h0,    0, 32'h505,      0, 4, 1, 0);
    add(0, 1, 1, 16'h0010, 16'h0000, 32'h0,        16'h0,    0, 32'h505,      0, 4, 1, 1);
    add(1, 0, 0, 16'h0000, 16'h0000, 32'h0,        16'h0,    0, 32'h0,        0, 0, 0, 0);
    // out-of-order response from slave 3 while head is slave 1
    add(0, 1, 1, 16'h0001, 16'h0000, 32'h0,        16'h0,    0, 32'h0,        0, 1, 0, 0);
    add(0, 1, 1, 16'h0002, 16'h0000, 32'h0,        16'h0,    0, 32'h0,        0, 2, 0, 0);
    add(0, 0, 0, 16'h0000, 16'h0001, 32'h10,       16'h0,    1, 32'h10,       0, 1, 0, 0);
    add(0, 0, 0, 16'h0000, 16'h0008, 32'h20,       16'h0,    0, 32'h10,       0, 1, 0, 1);
    add(0, 0, 0, 16'h0000, 16'h0002, 32'h30,       16'h0,    1, 32'h31,       0, 0, 0, 1);
    add(1, 0, 0, 16'h0000, 16'h0000, 32'h0,        16'h0,    0, 32'h0,        0, 0, 0, 0);
    // spurious response while empty
    add(0, 0, 0, 16'h0000, 16'h0001, 32'h40,       16'h0,    0, 32'h0,        0, 0, 0, 1);
    add(1, 0, 0, 16'h0000, 16'h0000, 32'h0,        16'h0,    0, 32'h0,        0, 0, 0, 0);
    // non-one-hot destination on an accepted request; request without grant ignored
    add(0, 1, 0, 16'h0001, 16'h0000, 32'h0,        16'h0,    0, 32'h0,        0, 0, 0, 0);
    add(0, 1, 1, 16'h0003, 16'h0000, 32'h0,        16'h0,    0, 32'h0,        0, 1, 0, 1);
    add(1, 0, 0, 16'h0000, 16'h0000, 32'h0,        16'h0,    0, 32'h0,        0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].gnt, tbl[i].dest, tbl[i].vld, tbl[i].rbase, tbl[i].opc);
      chk_all($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_rdata, tbl[i].e_opc,
              tbl[i].e_out, tbl[i].e_stall, tbl[i].e_err);
    end

    // Reset mid-flight: three outstanding, rst with a response in the same cycle.
    step(0, 1, 1, 16'h0001, 16'h0, 32'h0, 16'h0);
    step(0, 1, 1, 16'h0002, 16'h0, 32'h0, 16'h0);
    step(0, 1, 1, 16'h0004, 16'h0, 32'h0, 16'h0);
    chk_all("mid_fill", 0, 32'h0, 0, 3, 0, 0);
    step(1, 0, 0, 16'h0000, 16'h0001, 32'h77, 16'h1);
    chk_all("mid_rst", 0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0000, 32'h0, 16'h0);
    chk_all("mid_after", 0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 0, 16'h0000, 16'h0001, 32'h88, 16'h0);
    chk_all("mid_late", 0, 32'h0, 0, 0, 0, 1);
    step(1, 0, 0, 16'h0000, 16'h0000, 32'h0, 16'h0);
    chk_all("rnd_rst", 0, 32'h0, 0, 0, 0, 0);

    // Random legal in-order traffic; one injected stray bit late in the run.
    m_vld = 0; m_opc = 0; m_err = 0; m_rdata = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic          resp, q, g, popm;
      logic [NS-1:0] v, d, o, hmask;
      logic [DW-1:0] rb;
      int            di, hd;
      resp = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
      hd   = (mq.size() > 0) ? mq[0] : 0;
      v    = resp ? NS'(1) << hd : '0;
      if (cyc == 300) v = v | (NS'(1) << ((hd + 1) % NS));
      q    = ($urandom_range(0, 2) != 0) && ((mq.size() < MO) || resp);
      g    = $urandom_range(0, 3) != 0;
      di   = $urandom_range(0, NS - 1);
      d    = NS'(1) << di;
      rb   = $urandom;
      o    = NS'($urandom);

      hmask = (mq.size() > 0) ? (NS'(1) << mq[0]) : '0;
      popm  = (mq.size() > 0) && v[hd];
      if ((mq.size() == 0 && v != '0) || (mq.size() > 0 && (v & ~hmask) != '0)) m_err = 1;
      m_vld = popm;
      if (popm) begin
        m_rdata = rb + DW'(hd);
        m_opc   = o[hd];
      end
      if (q && g) begin
        if (mq.size() < MO || popm) begin
          if (popm) void'(mq.pop_front());
          mq.push_back(di);
        end else begin
          m_err = 1;
          if (popm) void'(mq.pop_front());
        end
      end else if (popm) begin
        void'(mq.pop_front());
      end

      step(0, q, g, d, v, rb, o);
      chk_all($sformatf("rnd%0d", cyc), m_vld, m_rdata, m_opc, CW'(mq.size()),
              mq.size() == MO, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xbar_bridge_resp_tracker.md
# xbar_bridge_resp_tracker

Response-side counterpart of the XBAR bridge request decoder. One instance per bridge master. It records the one-hot destination of every granted request in an in-order tracker and selects that slave's read response. It returns the response to the master one cycle later, registered. It also throttles new requests when the outstanding limit is reached.

## Interface

Parameters:
- N_SLAVE, 16, number of slave ports (one-hot destination width)
- DATA_WIDTH, 32, response data width
- MAX_OUTSTANDING, 4, tracker depth; power of two, ≥2

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req_i  in  1  master request (same signal driven into the request decoder)
- gnt_i  in  1  grant returned to master by the request decoder
- destination_i  in  N_SLAVE  one-hot target of current request
- req_stall_o  out  1  tracker full; upstream gates req_i while high
- data_r_valid_i  in  N_SLAVE  per-slave response valid (single-cycle pulse)
- data_r_rdata_i  in  N_SLAVE*DATA_WIDTH  per-slave response data, slave k at [k*DATA_WIDTH +: DATA_WIDTH]
- data_r_opc_i  in  N_SLAVE  per-slave error/opcode bit
- data_r_valid_o  out  1  response valid to master
- data_r_rdata_o  out  DATA_WIDTH  response data to master
- data_r_opc_o  out  1  response error bit to master
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight transaction count
- error_o  out  1  sticky protocol-violation flag

## Operation

- Accept condition: req_i & gnt_i.
  - When not full, push destination_i into the tracker FIFO.
  - When full, do not push, set error_o, and leave count unchanged.
- Head: the oldest destination in the FIFO, valid when count > 0.
- Pop condition: count > 0 and |(data_r_valid_i & head).
  - On pop, capture the head slave's rdata and opc into the output registers.
  - Set data_r_valid_o = 1 for one cycle.
- No pop in a cycle: data_r_valid_o = 0 next cycle; rdata and opc hold their previous values.
- Simultaneous push and pop: count unchanged; pointers both advance. This is legal at full, because the pop frees a slot in the same edge.
- req_stall_o = (count == MAX_OUTSTANDING). It is combinational from registered count and does not depend on a same-cycle pop.
- Violations set error_o, which is cleared only by rst:
  - any data_r_valid_i bit outside the head while count > 0;
  - any data_r_valid_i bit while count == 0;
  - destination_i not one-hot on an accepted request.
- Violating responses are dropped. A valid head response in the same cycle is still delivered.
- Slave responses must arrive in grant order. A slave responds at least one cycle after its grant, so there is no same-cycle push-to-pop bypass.
- Pointers are $clog2(MAX_OUTSTANDING) bits and wrap naturally. Full and empty are decided by count, not by pointer compare.

## Timing

- Reset values: data_r_valid_o=0, data_r_rdata_o=0, data_r_opc_o=0, outstanding_o=0, req_stall_o=0, error_o=0. Pointers are 0 and FIFO contents are don't-care.
- Latency: slave response in cycle N → data_r_valid_o in cycle N+1.
- outstanding_o reflects the push and pop of cycle N in cycle N+1.
- rst asserted mid-operation:
  - all in-flight entries are discarded;
  - responses arriving in the rst cycle are ignored;
  - in the first cycle after rst deasserts, all outputs hold reset values.
- Throughput: one accept and one response per cycle sustained.

## Structure

- Package xbar_bridge_pkg holds:
  - function onehot_to_idx(N_SLAVE) for head mux select;
  - function is_onehot for the destination check.
- Sub-module bridge_dest_fifo: synchronous FIFO of width N_SLAVE and depth MAX_OUTSTANDING.
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Contents are not reset.
- The top level contains only accept/pop logic, the response mux, output registers and the error flag.

## Test plan

- Single read: after rst, grant to destination 0x0004; slave 2 responds 3 cycles later with rdata 0xDEADBEEF.
  - Next cycle: data_r_valid_o=1, rdata=0xDEADBEEF.
  - outstanding_o goes 1 then 0.
- Fill and stall (MAX_OUTSTANDING=4): grant 4 back-to-back requests to slaves 0,1,2,3.
  - req_stall_o=1 and outstanding_o=4.
  - A fifth req_i&gnt_i sets error_o and outstanding_o stays 4.
- Simultaneous push/pop at full: slave 0 responds while a new grant to slave 5 arrives.
  - outstanding_o stays 4 and error_o stays 0.
  - Subsequent responses from 1,2,3,5 are delivered in order.
- Out-of-order response: head is slave 1 and slave 3 pulses valid.
  - error_o=1, no data_r_valid_o, count unchanged.
  - A later slave 1 response is delivered normally.
- Spurious response: count=0 and data_r_valid_i=0x0001 → error_o=1, data_r_valid_o stays 0.
- Reset mid-flight: 3 outstanding, then rst for 1 cycle.
  - All outputs are 0 after reset.
  - A late slave response then sets error_o (empty tracker).
